// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle integer ops plus iterative shift-add multiply and
// restoring divide, behind valid/ready handshakes on both sides.
module alu_seq #(
    parameter int DWIDTH = 32,
    parameter int SHW    = $clog2(DWIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] A,
    input  logic [DWIDTH-1:0] B,
    input  logic [3:0]        ctl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out,
    output logic              zero,
    output logic              illegal
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t                r_state, w_state_nxt;
    logic [3:0]            r_ctl;
    logic [DWIDTH-1:0]     r_opd;
    logic [2*DWIDTH-1:0]   r_prod;
    logic [SHW-1:0]        r_cnt;
    logic [DWIDTH-1:0]     r_out;
    logic                  r_zero, r_ill;

    logic                  w_is_mul, w_is_div, w_b_nz, w_last;
    logic [SHW-1:0]        w_sh;
    logic [DWIDTH-1:0]     w_alu, w_res;
    logic                  w_ill;
    logic [DWIDTH:0]       w_msum, w_shift, w_trial;
    logic [2*DWIDTH-1:0]   w_mul_nxt, w_div_nxt, w_iter;

    assign w_is_mul  = (ctl == 4'd10) || (ctl == 4'd11);
    assign w_is_div  = (ctl == 4'd13) || (ctl == 4'd14);
    assign w_b_nz    = (B != '0);
    assign w_last    = (r_cnt == SHW'(DWIDTH-1));
    assign w_sh      = B[SHW-1:0];

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out       = r_out;
    assign zero      = r_zero;
    assign illegal   = r_ill;

    // Only reached for DIVU/REMU when B == 0, so those entries are the div-by-zero results.
    always_comb begin
        w_alu = '0;
        w_ill = 1'b0;
        case (ctl)
            4'd0:  w_alu = A & B;
            4'd1:  w_alu = A | B;
            4'd2:  w_alu = A + B;
            4'd3:  w_alu = A ^ B;
            4'd4:  w_alu = A << w_sh;
            4'd5:  w_alu = A >> w_sh;
            4'd6:  w_alu = A - B;
            4'd7:  w_alu = {{(DWIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            4'd8:  w_alu = {{(DWIDTH-1){1'b0}}, (A < B)};
            4'd9:  w_alu = DWIDTH'($signed(A) >>> w_sh);
            4'd12: w_alu = ~(A | B);
            4'd13: w_alu = '1;
            4'd14: w_alu = A;
            4'd15: w_ill = 1'b1;
            default: w_alu = '0;
        endcase
    end

    // Multiply: product starts as {0, B}; LSB selects whether A is added to the upper half.
    assign w_msum    = {1'b0, r_prod[2*DWIDTH-1:DWIDTH]} + {1'b0, r_opd};
    assign w_mul_nxt = r_prod[0] ? {w_msum, r_prod[DWIDTH-1:1]}
                                 : {1'b0, r_prod[2*DWIDTH-1:1]};

    // Divide: upper half is the partial remainder, lower half shifts dividend out and quotient in.
    assign w_shift   = {r_prod[2*DWIDTH-1:DWIDTH], r_prod[DWIDTH-1]};
    assign w_trial   = w_shift - {1'b0, r_opd};
    assign w_div_nxt = w_trial[DWIDTH] ? {w_shift[DWIDTH-1:0], r_prod[DWIDTH-2:0], 1'b0}
                                       : {w_trial[DWIDTH-1:0], r_prod[DWIDTH-2:0], 1'b1};

    assign w_iter = (r_state == S_MUL) ? w_mul_nxt : w_div_nxt;

    always_comb begin
        w_res = w_iter[DWIDTH-1:0];
        if (r_ctl == 4'd11 || r_ctl == 4'd14)
            w_res = w_iter[2*DWIDTH-1:DWIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (in_valid) begin
                if (w_is_mul)                w_state_nxt = S_MUL;
                else if (w_is_div && w_b_nz) w_state_nxt = S_DIV;
                else                         w_state_nxt = S_DONE;
            end
            S_MUL, S_DIV: if (w_last) w_state_nxt = S_DONE;
            S_DONE: if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctl  <= '0;
            r_opd  <= '0;
            r_prod <= '0;
            r_cnt  <= '0;
            r_out  <= '0;
            r_zero <= 1'b0;
            r_ill  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_ctl  <= ctl;
                    r_cnt  <= '0;
                    r_opd  <= w_is_mul ? A : B;
                    r_prod <= {{DWIDTH{1'b0}}, (w_is_mul ? B : A)};
                    if (!w_is_mul && !(w_is_div && w_b_nz)) begin
                        r_out  <= w_alu;
                        r_zero <= (w_alu == '0);
                        r_ill  <= w_ill;
                    end
                end
                S_MUL, S_DIV: begin
                    r_prod <= w_iter;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_out  <= w_res;
                        r_zero <= (w_res == '0);
                        r_ill  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: expectations queued at accept, checked at out_valid
// together with the accept-to-valid latency.
module tb_alu_seq;
    localparam int W = 32;

    logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [W-1:0] A = '0, B = '0;
    logic [3:0]   ctl = '0;
    logic         in_ready, out_valid, zero, illegal;
    logic [W-1:0] dout;

    alu_seq #(.DWIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ctl(ctl), .out_valid(out_valid), .out_ready(out_ready),
        .out(dout), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         ill;
        int           lat;
        string        tag;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge while idle; returns at the negedge after the accepting edge.
    task automatic start_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] res, input logic ill, input int lat,
                            input string tag);
        exp_t e;
        chk({tag, "_in_ready"}, W'(in_ready), W'(1));
        ctl = c; A = a; B = b; in_valid = 1'b1;
        @(posedge clk);
        e.res = res; e.ill = ill; e.lat = lat; e.tag = tag;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        A = $urandom; B = $urandom; ctl = 4'($urandom);
    endtask

    task automatic wait_result();
        int   lat = 1;
        logic rdy_seen = 1'b0;
        exp_t e;
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_seen = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (in_ready) rdy_seen = 1'b1;
        chk("sb_size", W'(sb.size()), W'(1));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, "_valid"},   W'(out_valid), W'(1));
            chk({e.tag, "_out"},     dout, e.res);
            chk({e.tag, "_zero"},    W'(zero), W'(e.res == '0));
            chk({e.tag, "_illegal"}, W'(illegal), W'(e.ill));
            chk({e.tag, "_latency"}, W'(lat), W'(e.lat));
            chk({e.tag, "_busy"},    W'(rdy_seen), W'(0));
        end
    endtask

    task automatic op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] res, input logic ill, input int lat, input string tag);
        start_op(c, a, b, res, ill, lat, tag);
        wait_result();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0]   ra, rb;
        logic [2*W-1:0] p;

        repeat (3) @(negedge clk);
        chk("rst_in_ready",  W'(in_ready),  W'(1));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_out",       dout,          W'(0));
        chk("rst_zero",      W'(zero),      W'(0));
        chk("rst_illegal",   W'(illegal),   W'(0));
        rst_n = 1'b1;
        @(negedge clk);

        op(4'd0,  32'h0000_FFFF, 32'h00FF_00FF, 32'h0000_00FF, 1'b0, 1, "AND");
        op(4'd1,  32'h0000_FFFF, 32'h00FF_00FF, 32'h00FF_FFFF, 1'b0, 1, "OR");
        op(4'd3,  32'h0000_FFFF, 32'h00FF_00FF, 32'h00FF_FF00, 1'b0, 1, "XOR");
        op(4'd12, 32'h0000_FFFF, 32'h00FF_00FF, 32'hFF00_0000, 1'b0, 1, "NOR");
        op(4'd2,  32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1, "ADD_wrap");
        op(4'd6,  32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0, 1, "SUB_wrap");
        op(4'd7,  32'hFFFF_FFFF, 32'h0,         32'h1,         1'b0, 1, "SLT");
        op(4'd8,  32'hFFFF_FFFF, 32'h0,         32'h0,         1'b0, 1, "SLTU");
        op(4'd4,  32'h1,         32'h24,        32'h10,        1'b0, 1, "SLL");
        op(4'd9,  32'h8000_0000, 32'h24,        32'hF800_0000, 1'b0, 1, "SRA");
        op(4'd5,  32'h8000_0000, 32'h24,        32'h0800_0000, 1'b0, 1, "SRL");
        op(4'd10, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFE, 1'b0, 33, "MUL");
        op(4'd11, 32'hFFFF_FFFF, 32'h2,         32'h0000_0001, 1'b0, 33, "MULHU");
        op(4'd13, 32'd100,       32'd7,         32'd14,        1'b0, 33, "DIVU");
        op(4'd14, 32'd100,       32'd7,         32'd2,         1'b0, 33, "REMU");
        op(4'd13, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, 1, "DIVU_by0");
        op(4'd14, 32'd5,         32'd0,         32'd5,         1'b0, 1, "REMU_by0");
        op(4'd15, 32'h1234_5678, 32'h9,         32'h0,         1'b1, 1, "ILLEGAL");

        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = (i == 0) ? W'($urandom_range(1, 1000)) : ($urandom | 32'h1);
            p  = {{W{1'b0}}, ra} * {{W{1'b0}}, rb};
            op(4'd10, ra, rb, p[W-1:0],   1'b0, 33, "MUL_rnd");
            op(4'd11, ra, rb, p[2*W-1:W], 1'b0, 33, "MULHU_rnd");
            op(4'd13, ra, rb, ra / rb,    1'b0, 33, "DIVU_rnd");
            op(4'd14, ra, rb, ra % rb,    1'b0, 33, "REMU_rnd");
        end

        // Backpressure with a pending op waiting at the input.
        out_ready = 1'b0;
        start_op(4'd2, 32'd3, 32'd4, 32'd7, 1'b0, 1, "BP_ADD");
        wait_result();
        ctl = 4'd0; A = 32'h0000_F0F0; B = 32'h0000_FF00; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_out",   dout,           32'd7);
            chk("bp_hold_valid", W'(out_valid),  W'(1));
            chk("bp_no_accept",  W'(in_ready),   W'(0));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_idle_ready", W'(in_ready),  W'(1));
        chk("bp_idle_valid", W'(out_valid), W'(0));
        start_op(4'd0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1, "BP_AND");
        wait_result();
        @(posedge clk);
        @(negedge clk);

        // Reset in the middle of a divide abandons it.
        start_op(4'd13, 32'd100, 32'd7, 32'd14, 1'b0, 33, "DIV_abort");
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", W'(out_valid), W'(0));
        chk("midrst_in_ready",  W'(in_ready),  W'(1));
        chk("midrst_out",       dout,          W'(0));
        chk("midrst_illegal",   W'(illegal),   W'(0));
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        op(4'd15, 32'h0, 32'h0, 32'h0, 1'b1, 1, "ILLEGAL_post");
        op(4'd13, 32'd100, 32'd7, 32'd14, 1'b0, 33, "DIVU_post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
